// File: rtl/mod_cu_if.sv
// -----------------------------------------------------------------------------
// mod_cu_if
//   Bundles the handshake and datapath-control signals of the modulo control
//   unit, so that the host and datapath side can be connected as one port.
//
//   Host / datapath -> control unit:
//     start    : request a new operation
//     ack      : host acknowledges a finished result
//     b_zero   : datapath reports operand B == 0
//     dp_ge    : datapath reports temp >= B
//   Control unit -> host / datapath:
//     dp_load  : one-cycle strobe, datapath loads temp <= A
//     dp_sub   : one-cycle strobe, datapath performs temp <= temp - B
//     in_ready : unit is idle and will accept start
//     busy     : operation in progress
//     done     : result (or error) available, held until ack
//     err      : 00 ok, 01 divide-by-zero, 10 iteration timeout
//     iter_cnt : number of subtractions performed (quotient)
//
//   Modports: slave = control unit side, master = host/datapath side.
// -----------------------------------------------------------------------------
interface mod_cu_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             ack;
    logic             b_zero;
    logic             dp_ge;
    logic             dp_load;
    logic             dp_sub;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [1:0]       err;
    logic [CNT_W-1:0] iter_cnt;

    modport slave (
        input  start, ack, b_zero, dp_ge,
        output dp_load, dp_sub, in_ready, busy, done, err, iter_cnt
    );

    modport master (
        output start, ack, b_zero, dp_ge,
        input  dp_load, dp_sub, in_ready, busy, done, err, iter_cnt
    );
endinterface

// File: rtl/mod_cu.sv
// -----------------------------------------------------------------------------
// mod_cu
//   Control unit for an iterative (repeated-subtraction) modulo datapath.
//   Accepts a start request, rejects divide-by-zero, then issues one load
//   strobe followed by one subtract strobe per compare cycle while the
//   datapath reports temp >= B. The result status (done/err/iter_cnt) is held
//   until the host acknowledges it.
//
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-low reset
//     cu    : mod_cu_if.slave bundle (start/ack/b_zero/dp_ge in,
//             dp_load/dp_sub/in_ready/busy/done/err/iter_cnt out)
//
//   Parameters:
//     CNT_W    : width of the iteration counter
//     MAX_ITER : iteration limit, only active with MOD_TIMEOUT_EN
//
//   Build option:
//     MOD_TIMEOUT_EN : when defined, a compare that would start subtraction
//                      number MAX_ITER+1 ends the operation with err=10 instead.
// -----------------------------------------------------------------------------
module mod_cu #(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 1024
) (
    input  logic     clk,
    input  logic     reset,
    mod_cu_if.slave  cu
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CMP  = 3'd2,
        S_SUB  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

`ifdef MOD_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    // Limit disabled: the compare below folds to constant 0.
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] MAX_ITER_CNT = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
    logic             timeout_hit;

    assign timeout_hit = TIMEOUT_EN && (iter_cnt_q == MAX_ITER_CNT);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            err_q      <= ERR_OK;
            iter_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        iter_cnt_d = iter_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (cu.start) begin
                    // Clear the count for every accepted request so an error
                    // result never reports a stale quotient.
                    iter_cnt_d = '0;
                    err_d      = ERR_OK;
                    if (cu.b_zero) begin
                        state_d = S_ERR;
                        err_d   = ERR_DIV0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: state_d = S_CMP;
            S_CMP: begin
                if (cu.dp_ge) begin
                    if (timeout_hit) begin
                        state_d = S_ERR;
                        err_d   = ERR_TIMEOUT;
                    end else begin
                        state_d = S_SUB;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SUB: begin
                state_d = S_CMP;
                // Saturate rather than wrap; the loop itself keeps running.
                if (iter_cnt_q != CNT_SAT) begin
                    iter_cnt_d = iter_cnt_q + 1'b1;
                end
            end
            S_DONE, S_ERR: begin
                if (cu.ack) begin
                    state_d = S_IDLE;
                    err_d   = ERR_OK;
                end
            end
            default: begin
                state_d = S_IDLE;
                err_d   = ERR_OK;
            end
        endcase
    end

    // Output decode: every output comes straight from registered state.
    always_comb begin
        cu.dp_load  = (state_q == S_LOAD);
        cu.dp_sub   = (state_q == S_SUB);
        cu.in_ready = (state_q == S_IDLE);
        cu.busy     = (state_q == S_LOAD) || (state_q == S_CMP) || (state_q == S_SUB);
        cu.done     = (state_q == S_DONE) || (state_q == S_ERR);
        cu.err      = err_q;
        cu.iter_cnt = iter_cnt_q;
    end

endmodule
